// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp16_pkg
// Purpose  : Shared FP16 field widths, constants, alignment FSM state type and
//            the effective-exponent helper used by the alignment stage.
// Revision : 1.0  initial release
// ============================================================================
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int GRS_W = 3;
  localparam int SIG_W = 14;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Subnormals (exponent field 0) behave as if their exponent were 1.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? 5'd1 : e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_mag_compare.sv
`default_nettype none
// ============================================================================
// Module   : fp16_mag_compare
// Purpose  : Combinational {exp,man} magnitude comparator. Reports whether A is
//            greater than or equal to B and the effective-exponent difference
//            (big minus small, always non-negative).
// Ports    : i_a_exp/i_a_man, i_b_exp/i_b_man  operand fields
//            o_a_ge_b                          A >= B by magnitude
//            o_exp_diff                        eff_exp(big) - eff_exp(small)
// Revision : 1.0  initial release
// ============================================================================
module fp16_mag_compare
  import fp16_pkg::*;
(
  input  logic [EXP_W-1:0] i_a_exp,
  input  logic [MAN_W-1:0] i_a_man,
  input  logic [EXP_W-1:0] i_b_exp,
  input  logic [MAN_W-1:0] i_b_man,
  output logic             o_a_ge_b,
  output logic [EXP_W-1:0] o_exp_diff
);

  logic [EXP_W-1:0] w_a_eff;
  logic [EXP_W-1:0] w_b_eff;

  assign w_a_eff  = eff_exp(i_a_exp);
  assign w_b_eff  = eff_exp(i_b_exp);
  assign o_a_ge_b = ({i_a_exp, i_a_man} >= {i_b_exp, i_b_man});

  // The {exp,man} ordering implies eff_exp ordering, so this never wraps.
  assign o_exp_diff = o_a_ge_b ? (w_a_eff - w_b_eff) : (w_b_eff - w_a_eff);

endmodule
`default_nettype wire

// File: rtl/fp16_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : fp16_align_unit
// Purpose  : Sequential operand alignment for the FP16 adder. Latches an
//            operand pair, selects the larger magnitude, then right-shifts the
//            smaller significand one bit per cycle while folding shifted-out
//            bits into a sticky bit.
// Ports    : clk, reset                 clock, sync active-high reset
//            in_valid/in_ready, a, b    operand handshake (ready only in IDLE)
//            out_valid/out_ready        result handshake (valid only in DONE)
//            sign_big, sign_small, exp_big, sig_big, sig_small,
//            swapped, eff_sub, special  aligned result fields
// Revision : 1.0  initial release
// ============================================================================
module fp16_align_unit
  import fp16_pkg::*;
#(
  parameter int SIG_W     = 14,
  parameter int MAX_SHIFT = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_big,
  output logic             sign_small,
  output logic [4:0]       exp_big,
  output logic [SIG_W-1:0] sig_big,
  output logic [SIG_W-1:0] sig_small,
  output logic             swapped,
  output logic             eff_sub,
  output logic             special
);

  localparam logic [EXP_W-1:0] c_max_shift = EXP_W'(MAX_SHIFT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [4:0]       r_cnt;
  logic             r_sign_big;
  logic             r_sign_small;
  logic [4:0]       r_exp_big;
  logic [SIG_W-1:0] r_sig_big;
  logic [SIG_W-1:0] r_sig_small;
  logic             r_swapped;
  logic             r_special;

  logic             w_a_ge_b;
  logic [EXP_W-1:0] w_exp_diff;
  logic [SIG_W-1:0] w_sig_a;
  logic [SIG_W-1:0] w_sig_b;
  logic [SIG_W-1:0] w_sig_small_raw;
  logic             w_special;
  logic             w_collapse;
  logic             w_cmp_done;

  fp16_mag_compare u_cmp (
    .i_a_exp   (r_a[14:10]),
    .i_a_man   (r_a[9:0]),
    .i_b_exp   (r_b[14:10]),
    .i_b_man   (r_b[9:0]),
    .o_a_ge_b  (w_a_ge_b),
    .o_exp_diff(w_exp_diff)
  );

  assign w_sig_a = {(r_a[14:10] != '0), r_a[9:0], {GRS_W{1'b0}}};
  assign w_sig_b = {(r_b[14:10] != '0), r_b[9:0], {GRS_W{1'b0}}};
  assign w_sig_small_raw = w_a_ge_b ? w_sig_b : w_sig_a;

  assign w_special  = (r_a[14:10] == EXP_MAX) | (r_b[14:10] == EXP_MAX);
  assign w_collapse = (w_exp_diff >= c_max_shift);
  // Any of these finishes alignment straight from CMP with no shifting.
  assign w_cmp_done = w_special | w_collapse | (w_exp_diff == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)       w_state_nxt = CMP;
      CMP:     w_state_nxt = w_cmp_done ? DONE : SHIFT;
      SHIFT:   if (r_cnt == 5'd1)  w_state_nxt = DONE;
      DONE:    if (out_ready)      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: result registers only change in CMP/SHIFT, so DONE holds them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_sign_big   <= 1'b0;
      r_sign_small <= 1'b0;
      r_exp_big    <= '0;
      r_sig_big    <= '0;
      r_sig_small  <= '0;
      r_swapped    <= 1'b0;
      r_special    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a <= a;
            r_b <= b;
          end
        end
        CMP: begin
          r_swapped    <= ~w_a_ge_b;
          r_sign_big   <= w_a_ge_b ? r_a[15] : r_b[15];
          r_sign_small <= w_a_ge_b ? r_b[15] : r_a[15];
          r_exp_big    <= w_a_ge_b ? eff_exp(r_a[14:10]) : eff_exp(r_b[14:10]);
          r_sig_big    <= w_a_ge_b ? w_sig_a : w_sig_b;
          r_special    <= w_special;
          if (!w_special && w_collapse) begin
            r_sig_small <= {{(SIG_W-1){1'b0}}, |w_sig_small_raw};
          end else begin
            r_sig_small <= w_sig_small_raw;
          end
          r_cnt <= w_cmp_done ? 5'd0 : w_exp_diff;
        end
        SHIFT: begin
          // Logical shift right by one, with bit 0 accumulating sticky.
          r_sig_small <= {1'b0, r_sig_small[SIG_W-1:2], r_sig_small[1] | r_sig_small[0]};
          r_cnt       <= r_cnt - 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign sign_big   = r_sign_big;
  assign sign_small = r_sign_small;
  assign exp_big    = r_exp_big;
  assign sig_big    = r_sig_big;
  assign sig_small  = r_sig_small;
  assign swapped    = r_swapped;
  assign eff_sub    = r_sign_big ^ r_sign_small;
  assign special    = r_special;

endmodule
`default_nettype wire

// File: tb/tb_fp16_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_align_unit
// Purpose  : Self-checking bench for fp16_align_unit. Directed steps from the
//            block's behaviour list, then randomized operand pairs compared
//            against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp16_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        sign_big;
  logic        sign_small;
  logic [4:0]  exp_big;
  logic [13:0] sig_big;
  logic [13:0] sig_small;
  logic        swapped;
  logic        eff_sub;
  logic        special;

  int n_checks = 0;
  int n_errors = 0;

  fp16_align_unit #(.SIG_W(14), .MAX_SHIFT(14)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_big  (sign_big),
    .sign_small(sign_small),
    .exp_big   (exp_big),
    .sig_big   (sig_big),
    .sig_small (sig_small),
    .swapped   (swapped),
    .eff_sub   (eff_sub),
    .special   (special)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sb;
    logic        ss;
    logic [4:0]  eb;
    logic [13:0] gb;
    logic [13:0] gs;
    logic        sw;
    logic        sp;
    logic [4:0]  n;
  } ref_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({sign_big, sign_small, exp_big, sig_big, sig_small, swapped, eff_sub, special});
  endfunction

  // Reference: magnitudes, exponents and significands as plain integers.
  function automatic ref_t model(input logic [15:0] x, input logic [15:0] y);
    ref_t r;
    int ex, ey, mx, my, eex, eey, sigx, sigy, eb, es, gb, gs, d, sm;
    logic sw, sp;
    ex   = int'(x[14:10]);
    ey   = int'(y[14:10]);
    mx   = int'(x[9:0]);
    my   = int'(y[9:0]);
    sw   = ((ey * 1024 + my) > (ex * 1024 + mx));
    eex  = (ex == 0) ? 1 : ex;
    eey  = (ey == 0) ? 1 : ey;
    sigx = ((ex != 0) ? 8192 : 0) + mx * 8;
    sigy = ((ey != 0) ? 8192 : 0) + my * 8;
    if (sw) begin
      eb = eey; es = eex; gb = sigy; gs = sigx;
    end else begin
      eb = eex; es = eey; gb = sigx; gs = sigy;
    end
    d   = eb - es;
    sp  = (ex == 31) || (ey == 31);
    r.n = 5'd0;
    if (sp) begin
      sm = gs;
    end else if (d >= 14) begin
      sm = (gs != 0) ? 1 : 0;
    end else begin
      sm  = (gs >> d) | (((gs % (1 << d)) != 0) ? 1 : 0);
      r.n = 5'(d);
    end
    r.sb = sw ? y[15] : x[15];
    r.ss = sw ? x[15] : y[15];
    r.eb = 5'(eb);
    r.gb = 14'(gb);
    r.gs = 14'(sm);
    r.sw = sw;
    r.sp = sp;
    return r;
  endfunction

  // Starts at a negedge in IDLE; ends at a negedge in IDLE after consumption.
  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_v, input int hold);
    ref_t        e;
    int          lat;
    logic [63:0] snap;
    e = model(ta, tb_v);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    a         = ta;
    b         = tb_v;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("in_ready_busy", 64'(in_ready), 64'd0);
        a = 16'($urandom);
        b = 16'($urandom);
      end
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(2 + int'(e.n)));
    check("swapped", 64'(swapped), 64'(e.sw));
    check("sign_big", 64'(sign_big), 64'(e.sb));
    check("sign_small", 64'(sign_small), 64'(e.ss));
    check("exp_big", 64'(exp_big), 64'(e.eb));
    check("sig_big", 64'(sig_big), 64'(e.gb));
    check("sig_small", 64'(sig_small), 64'(e.gs));
    check("eff_sub", 64'(eff_sub), 64'(e.sb ^ e.ss));
    check("special", 64'(special), 64'(e.sp));
    snap = outs();
    if (hold > 0) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_outputs", outs(), snap);
      check("hold_valid_ready", 64'({out_valid, in_ready}), 64'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("consumed", 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          seen;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", outs(), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Plain shift by one
    run_txn(16'h3C00, 16'h3800, 0);
    check("plain_sig_small", 64'(sig_small), 64'h1000);
    check("plain_exp_big", 64'(exp_big), 64'd15);
    // Swap with effective subtract
    run_txn(16'h3800, 16'hC000, 0);
    check("swap_sig_small", 64'(sig_small), 64'h0800);
    check("swap_flags", 64'({swapped, sign_big, eff_sub}), 64'b111);
    // Sticky capture
    run_txn(16'h4C00, 16'h3C01, 0);
    check("sticky_sig_small", 64'(sig_small), 64'h0201);
    // Collapse with subnormal small operand
    run_txn(16'h7800, 16'h0001, 0);
    check("collapse_sig_small", 64'(sig_small), 64'h0001);
    // Equal operands
    run_txn(16'h3C00, 16'h3C00, 0);
    check("equal_sig_small", 64'(sig_small), 64'h2000);
    check("equal_swapped", 64'(swapped), 64'd0);
    // Special input
    run_txn(16'h7C00, 16'h3C00, 0);
    check("special_flag", 64'(special), 64'd1);
    // Backpressure for five cycles
    run_txn(16'h3C00, 16'h3800, 5);
    run_txn(16'h4C00, 16'h3C01, 3);

    // Reset during SHIFT aborts the pair
    a = 16'h4C00; b = 16'h3C01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_sig_small", 64'(sig_small), 64'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_output", 64'(seen), 64'd0);

    // Randomized pairs with a mix of near and far exponents
    for (int t = 0; t < 150; t++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          ra[14:10] = 5'($urandom_range(0, 20));
          rb[14:10] = 5'($urandom_range(0, 20));
        end
        1: rb[14:10] = 5'd0;
        2: rb[14:10] = ra[14:10];
        default: begin
        end
      endcase
      run_txn(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
